// File: rtl/freq_peak_select.sv
// freq_peak_select: picks the strongest per-bin arg_max result over one
// frequency sweep and presents it downstream with a valid/ready handshake.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   m_axis_tvalid    upstream result valid
//   in_max, in_index upstream peak magnitude / time index
//   s_axis_tready    ready to accept an upstream result (registered)
//   threshold        detection threshold, sampled on bin 0 of each sweep
//   sweep_restart    synchronous sweep abort, highest priority
//   m_axis_tready    downstream ready
//   s_axis_tvalid    sweep result valid
//   peak_mag/index/freq, detect  registered sweep result
module freq_peak_select #(
  parameter int unsigned freq_bins       = 8,
  parameter int unsigned freq_index_bits = 3,
  parameter int unsigned index_bits      = 4,
  parameter int unsigned out_max_bits    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_axis_tvalid,
  input  logic [out_max_bits-1:0]    in_max,
  input  logic [index_bits-1:0]      in_index,
  output logic                       s_axis_tready,
  input  logic [out_max_bits-1:0]    threshold,
  input  logic                       sweep_restart,
  input  logic                       m_axis_tready,
  output logic                       s_axis_tvalid,
  output logic [out_max_bits-1:0]    peak_mag,
  output logic [index_bits-1:0]      peak_index,
  output logic [freq_index_bits-1:0] peak_freq,
  output logic                       detect
);

  localparam int unsigned FW = freq_index_bits;
  localparam int unsigned IW = index_bits;
  localparam int unsigned MW = out_max_bits;
  localparam logic [FW-1:0] LAST_BIN = FW'(freq_bins - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] bin_q, bin_d;
  logic [MW-1:0] thr_q, thr_d;
  logic [MW-1:0] best_mag_q, best_mag_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [FW-1:0] best_freq_q, best_freq_d;
  logic          tready_d, tvalid_d, detect_d;
  logic [MW-1:0] peak_mag_d;
  logic [IW-1:0] peak_index_d;
  logic [FW-1:0] peak_freq_d;

  logic          xfer;
  logic          first_bin, last_bin, take;
  logic [MW-1:0] cand_mag, thr_eff;
  logic [IW-1:0] cand_idx;
  logic [FW-1:0] cand_freq;

  assign xfer      = m_axis_tvalid & s_axis_tready;
  assign first_bin = (bin_q == '0);
  assign last_bin  = (bin_q == LAST_BIN);
  // Bin 0 always loads; later bins win only on a strictly larger magnitude.
  assign take      = first_bin | (in_max > best_mag_q);
  assign cand_mag  = take ? in_max : best_mag_q;
  assign cand_idx  = take ? in_index : best_idx_q;
  assign cand_freq = take ? bin_q : best_freq_q;
  // On a single-bin sweep the threshold is sampled on the very edge it is used.
  assign thr_eff   = first_bin ? threshold : thr_q;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ACCUM;
      bin_q         <= '0;
      thr_q         <= '0;
      best_mag_q    <= '0;
      best_idx_q    <= '0;
      best_freq_q   <= '0;
      s_axis_tready <= 1'b0;
      s_axis_tvalid <= 1'b0;
      peak_mag      <= '0;
      peak_index    <= '0;
      peak_freq     <= '0;
      detect        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bin_q         <= bin_d;
      thr_q         <= thr_d;
      best_mag_q    <= best_mag_d;
      best_idx_q    <= best_idx_d;
      best_freq_q   <= best_freq_d;
      s_axis_tready <= tready_d;
      s_axis_tvalid <= tvalid_d;
      peak_mag      <= peak_mag_d;
      peak_index    <= peak_index_d;
      peak_freq     <= peak_freq_d;
      detect        <= detect_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (sweep_restart) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (xfer && last_bin) state_d = HOLD;
        HOLD:    if (m_axis_tready)    state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    bin_d        = bin_q;
    thr_d        = thr_q;
    best_mag_d   = best_mag_q;
    best_idx_d   = best_idx_q;
    best_freq_d  = best_freq_q;
    tvalid_d     = s_axis_tvalid;
    peak_mag_d   = peak_mag;
    peak_index_d = peak_index;
    peak_freq_d  = peak_freq;
    detect_d     = detect;
    tready_d     = (state_d == ACCUM);

    if (sweep_restart) begin
      // Abort: drop partial sweep and any pending result, keep last peak_*.
      bin_d       = '0;
      best_mag_d  = '0;
      best_idx_d  = '0;
      best_freq_d = '0;
      tvalid_d    = 1'b0;
    end else begin
      if (state_q == ACCUM && xfer) begin
        best_mag_d  = cand_mag;
        best_idx_d  = cand_idx;
        best_freq_d = cand_freq;
        if (first_bin) thr_d = threshold;
        if (last_bin) begin
          bin_d        = '0;
          peak_mag_d   = cand_mag;
          peak_index_d = cand_idx;
          peak_freq_d  = cand_freq;
          detect_d     = (cand_mag >= thr_eff);
          tvalid_d     = 1'b1;
        end else begin
          bin_d = bin_q + FW'(1);
        end
      end
      if (state_q == HOLD && m_axis_tready) tvalid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_peak_select.sv
// Scoreboard bench for freq_peak_select (4 bins, 4-bit magnitude/index).
module tb_freq_peak_select;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_axis_tvalid = 1'b0;
  logic [3:0] in_max = '0;
  logic [3:0] in_index = '0;
  logic       s_axis_tready;
  logic [3:0] threshold = '0;
  logic       sweep_restart = 1'b0;
  logic       m_axis_tready = 1'b0;
  logic       s_axis_tvalid;
  logic [3:0] peak_mag;
  logic [3:0] peak_index;
  logic [1:0] peak_freq;
  logic       detect;

  freq_peak_select #(
    .freq_bins(NB), .freq_index_bits(2), .index_bits(4), .out_max_bits(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_axis_tvalid(m_axis_tvalid), .in_max(in_max),
    .in_index(in_index), .s_axis_tready(s_axis_tready), .threshold(threshold),
    .sweep_restart(sweep_restart), .m_axis_tready(m_axis_tready),
    .s_axis_tvalid(s_axis_tvalid), .peak_mag(peak_mag), .peak_index(peak_index),
    .peak_freq(peak_freq), .detect(detect)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mag;
    logic [3:0] idx;
    logic [1:0] freq;
    logic       det;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: values accepted so far in the current sweep.
  int   sw_mag[$];
  int   sw_idx[$];
  int   sw_thr;

  bit   rand_ready = 0;
  bit   ready_force = 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    sw_mag.delete();
    sw_idx.delete();
  endtask

  // A sweep result is the first bin holding the maximum magnitude.
  task automatic model_accept(input int mag, input int idx, input int thr);
    exp_t e;
    int   best;
    if (sw_mag.size() == 0) sw_thr = thr;
    sw_mag.push_back(mag);
    sw_idx.push_back(idx);
    if (sw_mag.size() == NB) begin
      best = 0;
      for (int i = 1; i < NB; i++)
        if (sw_mag[i] > sw_mag[best]) best = i;
      e.mag  = 4'(sw_mag[best]);
      e.idx  = 4'(sw_idx[best]);
      e.freq = 2'(best);
      e.det  = (sw_mag[best] >= sw_thr);
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  // Present one result; while not ready, junk data is shown instead.
  task automatic send(input int mag, input int idx, input int thr);
    bit done = 0;
    int tries = 0;
    while (!done) begin
      @(negedge clk);
      m_axis_tvalid = 1'b1;
      if (s_axis_tready) begin
        in_max = 4'(mag); in_index = 4'(idx); threshold = 4'(thr);
        model_accept(mag, idx, thr);
        done = 1;
      end else begin
        in_max = 4'($urandom); in_index = 4'($urandom);
        tries++;
        if (tries > 200) begin
          check("send_timeout", 0, 1);
          done = 1;
        end
      end
      @(posedge clk);
      #1 m_axis_tvalid = 1'b0;
    end
  endtask

  // Restart pulse with a concurrent transfer that must be dropped.
  task automatic restart_pulse(input int mag);
    @(negedge clk);
    sweep_restart = 1'b1;
    m_axis_tvalid = 1'b1;
    in_max = 4'(mag);
    model_clear();
    @(posedge clk);
    #1;
    sweep_restart = 1'b0;
    m_axis_tvalid = 1'b0;
  endtask

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1 m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: pops an expectation when a result appears, checks it while held.
  exp_t cur;
  bit   prev_valid = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      if (s_axis_tvalid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
          cur.mag = peak_mag; cur.idx = peak_index;
          cur.freq = peak_freq; cur.det = detect;
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (s_axis_tvalid) begin
        check("peak_mag", int'(peak_mag), int'(cur.mag));
        check("peak_index", int'(peak_index), int'(cur.idx));
        check("peak_freq", int'(peak_freq), int'(cur.freq));
        check("detect", int'(detect), int'(cur.det));
      end
      prev_valid = s_axis_tvalid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((s_axis_tvalid || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(n < 300), 1);
  endtask

  initial begin
    int gap;
    // Reset values.
    #12;
    check("rst_tready", int'(s_axis_tready), 0);
    check("rst_tvalid", int'(s_axis_tvalid), 0);
    check("rst_peak_mag", int'(peak_mag), 0);
    check("rst_peak_index", int'(peak_index), 0);
    check("rst_peak_freq", int'(peak_freq), 0);
    check("rst_detect", int'(detect), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("tready_after_reset", int'(s_axis_tready), 1);

    // Basic sweep.
    ready_force = 1;
    send(3, 1, 8); send(9, 2, 8); send(5, 3, 8); send(9, 4, 8);
    @(negedge clk);
    check("sweep_valid", int'(s_axis_tvalid), 1);
    check("sweep_mag", int'(peak_mag), 9);
    check("sweep_idx", int'(peak_index), 2);
    check("sweep_freq", int'(peak_freq), 1);
    check("sweep_det", int'(detect), 1);
    @(negedge clk);
    check("sweep_valid_1cyc", int'(s_axis_tvalid), 0);
    check("retain_mag", int'(peak_mag), 9);
    check("ready_after_hs", int'(s_axis_tready), 1);

    // Backpressure: result held, HOLD-time data ignored.
    ready_force = 0;
    send(2, 5, 8); send(2, 6, 8); send(2, 7, 8); send(7, 8, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_axis_tvalid = 1'b1; in_max = 4'd15;
      check("bp_valid", int'(s_axis_tvalid), 1);
      check("bp_tready", int'(s_axis_tready), 0);
      check("bp_mag", int'(peak_mag), 7);
      check("bp_freq", int'(peak_freq), 3);
      check("bp_det", int'(detect), 0);
    end
    m_axis_tvalid = 1'b0;
    ready_force = 1;
    wait_idle();

    // Threshold sampled only on bin 0.
    send(4, 1, 4); send(0, 2, 4); send(0, 3, 15); send(0, 4, 15);
    @(negedge clk);
    check("thr_det", int'(detect), 1);
    check("thr_freq", int'(peak_freq), 0);
    wait_idle();

    // Restart mid-sweep with a dropped concurrent transfer.
    send(15, 1, 0); send(15, 2, 0);
    restart_pulse(15);
    send(1, 1, 0); send(2, 2, 0); send(3, 3, 0); send(4, 4, 0);
    @(negedge clk);
    check("rs_mag", int'(peak_mag), 4);
    check("rs_freq", int'(peak_freq), 3);
    wait_idle();

    // Restart in HOLD drops the result, peak outputs unchanged.
    ready_force = 0;
    send(6, 1, 0); send(1, 2, 0); send(1, 3, 0); send(1, 4, 0);
    @(negedge clk);
    restart_pulse(0);
    @(negedge clk);
    check("rh_valid", int'(s_axis_tvalid), 0);
    check("rh_mag", int'(peak_mag), 6);
    check("rh_tready", int'(s_axis_tready), 1);
    ready_force = 1;

    // Async reset while in HOLD.
    ready_force = 0;
    send(8, 9, 1); send(1, 1, 1); send(1, 1, 1); send(1, 1, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_tvalid", int'(s_axis_tvalid), 0);
    check("ar_tready", int'(s_axis_tready), 0);
    check("ar_mag", int'(peak_mag), 0);
    check("ar_idx", int'(peak_index), 0);
    check("ar_freq", int'(peak_freq), 0);
    check("ar_det", int'(detect), 0);
    model_clear();
    ready_force = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ar_tready_after", int'(s_axis_tready), 1);
    send(1, 3, 2); send(5, 4, 2); send(2, 5, 2); send(5, 6, 2);
    wait_idle();

    // Randomized sweeps with random backpressure and occasional restarts.
    rand_ready = 1;
    for (int n = 0; n < 160; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 19) == 0)
        restart_pulse(int'($urandom_range(0, 15)));
      else if ($urandom_range(0, 1) == 1)
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)));
      else
        send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)));
    end
    rand_ready = 0;
    ready_force = 1;
    wait_idle();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
